// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with clock-enable stepping, runtime seed load,
// lock-up detection and a measured-period readout.
module lfsr_gen #(
    parameter int              WIDTH = 20,
    parameter logic [WIDTH-1:0] TAPS  = 20'h90000,
    parameter logic [WIDTH-1:0] SEED  = 20'h34713,
    parameter bit              XNOR  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] state,
    output logic             lfsr_out,
    output logic             max_tick,
    output logic             lockup,
    output logic [WIDTH-1:0] period,
    output logic             period_valid
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    // XNOR feedback sticks at all-ones, XOR feedback sticks at all-zeros.
    localparam logic [WIDTH-1:0] LOCK_VAL = {WIDTH{XNOR}};

    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be in 3..32");
    end
    if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
        $error("lfsr_gen: TAPS[WIDTH-1] must be set");
    end

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == ALL_ONES) ? v : v + ONE;
    endfunction

    function automatic logic feedback(input logic [WIDTH-1:0] s);
        return (^(s & TAPS)) ^ XNOR;
    endfunction

    logic [WIDTH-1:0] lfsr_reg;
    logic [WIDTH-1:0] start_ref;
    logic [WIDTH-1:0] step_count;
    logic [WIDTH-1:0] period_reg;
    logic             valid_reg;
    logic             tick_reg;
    logic             lock_reg;

    logic [WIDTH-1:0] next_state;
    logic             wrap_hit;

    always_comb begin
        next_state = {lfsr_reg[WIDTH-2:0], feedback(lfsr_reg)};
        wrap_hit   = (next_state == start_ref);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_reg   <= SEED;
            start_ref  <= SEED;
            step_count <= '0;
            period_reg <= '0;
            valid_reg  <= 1'b0;
            tick_reg   <= 1'b0;
            lock_reg   <= (SEED == LOCK_VAL);
        end else if (load) begin
            // Load outranks en: no step, and the measurement restarts here.
            lfsr_reg   <= load_value;
            start_ref  <= load_value;
            step_count <= '0;
            valid_reg  <= 1'b0;
            tick_reg   <= 1'b0;
            lock_reg   <= (load_value == LOCK_VAL);
        end else if (en) begin
            lfsr_reg <= next_state;
            lock_reg <= (next_state == LOCK_VAL);
            if (wrap_hit) begin
                tick_reg   <= 1'b1;
                period_reg <= sat_inc(step_count);
                valid_reg  <= 1'b1;
                step_count <= '0;
            end else begin
                tick_reg   <= 1'b0;
                step_count <= sat_inc(step_count);
            end
        end else begin
            tick_reg <= 1'b0;
        end
    end

    assign state        = lfsr_reg;
    assign lfsr_out     = lfsr_reg[WIDTH-1];
    assign max_tick     = tick_reg;
    assign lockup       = lock_reg;
    assign period       = period_reg;
    assign period_valid = valid_reg;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: directed steps plus randomized stimulus on a default
// 20-bit instance and a 4-bit XOR instance, both tracked by a reference model.
module tb_lfsr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, en_a = 1'b0, load_a = 1'b0;
    logic [19:0] lv_a = '0;
    logic [19:0] state_a, period_a;
    logic        out_a, tick_a, lock_a, pv_a;

    logic        rst_b = 1'b1, en_b = 1'b0, load_b = 1'b0;
    logic [3:0]  lv_b = '0;
    logic [3:0]  state_b, period_b;
    logic        out_b, tick_b, lock_b, pv_b;

    lfsr_gen dut_a (
        .clk(clk), .reset(rst_a), .en(en_a), .load(load_a), .load_value(lv_a),
        .state(state_a), .lfsr_out(out_a), .max_tick(tick_a), .lockup(lock_a),
        .period(period_a), .period_valid(pv_a)
    );

    lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .XNOR(1'b0)) dut_b (
        .clk(clk), .reset(rst_b), .en(en_b), .load(load_b), .load_value(lv_b),
        .state(state_b), .lfsr_out(out_b), .max_tick(tick_b), .lockup(lock_b),
        .period(period_b), .period_valid(pv_b)
    );

    typedef struct {
        int unsigned st, start, cnt, per;
        bit          pv, tick, lock;
    } mdl_t;

    mdl_t ma, mb;
    int   checks = 0;
    int   passed = 0;

    // Reference behaviour: shift left, new LSB is the parity of tapped bits
    // (inverted for XNOR); count steps since start, report the cycle length.
    function automatic mdl_t mstep(mdl_t m, int w, int unsigned taps, int unsigned seed,
                                   bit xn, bit rst, bit ld, int unsigned lv, bit e);
        int unsigned mask, lockv, nxt;
        mask  = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        lockv = xn ? mask : 32'd0;
        if (rst) begin
            m.st = seed; m.start = seed; m.cnt = 0; m.per = 0;
            m.pv = 0; m.tick = 0; m.lock = (seed == lockv);
        end else if (ld) begin
            m.st = lv & mask; m.start = lv & mask; m.cnt = 0;
            m.pv = 0; m.tick = 0; m.lock = ((lv & mask) == lockv);
        end else if (e) begin
            nxt  = ((m.st << 1) & mask) | ((($countones(m.st & taps) % 2) != 0) ^ xn);
            m.st = nxt;
            m.lock = (nxt == lockv);
            if (nxt == m.start) begin
                m.tick = 1; m.pv = 1;
                m.per  = (m.cnt + 1 > mask) ? mask : m.cnt + 1;
                m.cnt  = 0;
            end else begin
                m.tick = 0;
                m.cnt  = (m.cnt + 1 > mask) ? mask : m.cnt + 1;
            end
        end else begin
            m.tick = 0;
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // One clock: advance both models with the inputs seen at the edge, then
    // compare every output of both instances just after the edge.
    task automatic cycle();
        @(posedge clk);
        ma = mstep(ma, 20, 32'h90000, 32'h34713, 1'b1, rst_a, load_a, lv_a, en_a);
        mb = mstep(mb, 4, 32'hC, 32'h1, 1'b0, rst_b, load_b, lv_b, en_b);
        #1;
        chk("a_state", state_a, ma.st);
        chk("a_out", out_a, ma.st[19]);
        chk("a_tick", tick_a, ma.tick);
        chk("a_lock", lock_a, ma.lock);
        chk("a_period", period_a, ma.per);
        chk("a_pv", pv_a, ma.pv);
        chk("b_state", state_b, mb.st);
        chk("b_out", out_b, mb.st[3]);
        chk("b_tick", tick_b, mb.tick);
        chk("b_lock", lock_b, mb.lock);
        chk("b_period", period_b, mb.per);
        chk("b_pv", pv_b, mb.pv);
    endtask

    initial begin
        int          ticks[$];
        int          gap;
        logic [3:0]  held;
        bit          seen;

        // Reset values
        cycle(); cycle();
        chk("rst_state", state_a, 32'h34713);
        chk("rst_period", period_a, 0);
        chk("rst_flags", {tick_a, lock_a, pv_a}, 3'b000);
        chk("rst_b_state", state_b, 4'h1);
        rst_a = 1'b0; rst_b = 1'b0;

        // Default sequence from seed
        en_a = 1'b1;
        cycle();
        chk("seq1", state_a, 32'h68E26);
        chk("seq1_out", out_a, 1'b0);
        cycle();
        chk("seq2", state_a, 32'hD1C4D);
        chk("seq2_out", out_a, 1'b1);
        chk("seq_flags", {tick_a, lock_a, pv_a}, 3'b000);

        // Lock-up via load of all-ones
        en_a = 1'b0; load_a = 1'b1; lv_a = 20'hFFFFF;
        cycle();
        chk("lk_load_lock", lock_a, 1'b1);
        chk("lk_load_pv", pv_a, 1'b0);
        load_a = 1'b0; en_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("lk_state", state_a, 32'hFFFFF);
            chk("lk_tick", tick_a, 1'b1);
            chk("lk_period", period_a, 1);
            chk("lk_lock", lock_a, 1'b1);
        end
        en_a = 1'b0; load_a = 1'b1; lv_a = 20'h00001;
        cycle();
        chk("unlk_lock", lock_a, 1'b0);
        chk("unlk_pv", pv_a, 1'b0);
        chk("unlk_period_held", period_a, 1);

        // Load and en together mid-run
        load_a = 1'b0; en_a = 1'b1;
        repeat (5) cycle();
        load_a = 1'b1; lv_a = 20'h12345;
        cycle();
        chk("ld_en_state", state_a, 32'h12345);
        chk("ld_en_tick", tick_a, 1'b0);
        load_a = 1'b0;
        repeat (4) cycle();

        // Reset mid-run
        rst_a = 1'b1;
        cycle();
        chk("midrst_state", state_a, 32'h34713);
        chk("midrst_period", period_a, 0);
        rst_a = 1'b0; en_a = 1'b0;

        // 4-bit XOR instance: maximal period 15
        rst_b = 1'b1; cycle(); rst_b = 1'b0; en_b = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            cycle();
            if (tick_b) ticks.push_back(i);
        end
        chk("b_tick_count", ticks.size(), 3);
        if (ticks.size() >= 3) begin
            chk("b_first_tick", ticks[0], 15);
            chk("b_spacing1", ticks[1] - ticks[0], 15);
            chk("b_spacing2", ticks[2] - ticks[1], 15);
        end
        chk("b_period15", period_b, 15);
        chk("b_pv", pv_b, 1'b1);

        // en gap of 3 cycles stretches the tick spacing to 18
        rst_b = 1'b1; cycle(); rst_b = 1'b0; en_b = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cycle();
            seen = tick_b;
        end
        chk("gap_first_tick_seen", seen, 1'b1);
        gap = 0;
        repeat (5) begin cycle(); gap++; end
        en_b = 1'b0;
        held = state_b;
        repeat (3) begin
            cycle(); gap++;
            chk("gap_hold", state_b, held);
        end
        en_b = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cycle(); gap++;
            seen = tick_b;
        end
        chk("gap_second_tick_seen", seen, 1'b1);
        chk("gap_spacing", gap, 18);
        chk("gap_period", period_b, 15);

        // Randomized stimulus on both instances
        for (int i = 0; i < 3000; i++) begin
            rst_a  = ($urandom_range(0, 299) == 0);
            load_a = ($urandom_range(0, 39) == 0);
            en_a   = ($urandom_range(0, 3) != 0);
            lv_a   = ($urandom_range(0, 3) == 0) ? 20'hFFFFF : 20'($urandom);
            rst_b  = ($urandom_range(0, 299) == 0);
            load_b = ($urandom_range(0, 49) == 0);
            en_b   = ($urandom_range(0, 4) != 0);
            lv_b   = 4'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
